// File: rtl/mux2_rr_arbiter.sv
// Round-robin, packet-based arbiter sharing one 2:1 valid/ready datapath between
// requesters A (sel 0) and B (sel 1); grant is registered, data path is pass-through.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;   // 0 = A has priority, 1 = B
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             burst_end;

  // Priority source first, then the other one; nothing granted while disabled.
  function automatic state_e arb(input logic en_i, input logic pick_b,
                                 input logic av, input logic bv);
    state_e res;
    res = IDLE;
    if (en_i) begin
      if (pick_b) res = bv ? GNT_B : (av ? GNT_A : IDLE);
      else        res = av ? GNT_A : (bv ? GNT_B : IDLE);
    end
    return res;
  endfunction

  assign burst_end = (cnt_q == LAST_BEAT);

  // At end of grant the beat being accepted is not a fresh request, so the
  // finishing source's valid is masked when re-arbitrating.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    y_valid = 1'b0;
    y_data  = '0;
    y_last  = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      IDLE: state_d = arb(en, prio_q, a_valid, b_valid);
      GNT_A: begin
        y_valid = a_valid;
        y_data  = a_data;
        y_last  = a_last | burst_end;
        a_ready = y_ready;
        if (a_valid && y_ready) begin
          if (a_last || burst_end) begin
            cnt_d   = '0;
            prio_d  = 1'b1;
            state_d = arb(en, 1'b1, 1'b0, b_valid);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GNT_B: begin
        y_valid = b_valid;
        y_data  = b_data;
        y_last  = b_last | burst_end;
        b_ready = y_ready;
        if (b_valid && y_ready) begin
          if (b_last || burst_end) begin
            cnt_d   = '0;
            prio_d  = 1'b0;
            state_d = arb(en, 1'b0, a_valid, 1'b0);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    sel_d  = (state_d == IDLE) ? sel_q : (state_d == GNT_B);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4) with hand-computed
// per-cycle expectations on all outputs.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_last = 1'b0, b_last = 1'b0;
  logic       a_ready, b_ready, y_valid, y_last, sel, busy;
  logic [7:0] y_data;
  logic       y_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Check every output one time unit after inputs for this cycle were applied.
  task automatic cyc(input string tag, input logic e_busy, input logic e_sel,
                     input logic e_yv, input logic [7:0] e_yd, input logic e_yl,
                     input logic e_ar, input logic e_br);
    #1;
    chk({tag, ".busy"},    32'(busy),    32'(e_busy));
    chk({tag, ".sel"},     32'(sel),     32'(e_sel));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(e_yv));
    chk({tag, ".y_data"},  32'(y_data),  32'(e_yd));
    chk({tag, ".y_last"},  32'(y_last),  32'(e_yl));
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(e_ar));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(e_br));
  endtask

  initial begin
    // Reset applied asynchronously while both requesters are valid
    #1;
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB;
    cyc("rst_async", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); nxt();
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    cyc("rst_rel", 0, 0, 0, 8'h00, 0, 0, 0);

    // A alone, 3-beat packet
    nxt(); a_valid = 1; a_data = 8'h11; a_last = 0;
    cyc("a3_req", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("a3_b1", 1, 0, 1, 8'h11, 0, 1, 0);
    nxt(); a_data = 8'h12;
    cyc("a3_b2", 1, 0, 1, 8'h12, 0, 1, 0);
    nxt(); a_data = 8'h13; a_last = 1;
    cyc("a3_b3", 1, 0, 1, 8'h13, 1, 1, 0);
    nxt(); a_valid = 0; a_last = 0;
    cyc("a3_idle", 0, 0, 0, 8'h00, 0, 0, 0);

    // Priority now B: both request single beats, B wins, then A back-to-back
    nxt(); a_valid = 1; a_data = 8'h21; a_last = 1; b_valid = 1; b_data = 8'h31; b_last = 1;
    cyc("pb_req", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("pb_b", 1, 1, 1, 8'h31, 1, 0, 1);
    nxt(); b_valid = 0; b_last = 0;
    cyc("pb_a", 1, 0, 1, 8'h21, 1, 1, 0);
    nxt(); a_valid = 0; a_last = 0; b_valid = 1; b_data = 8'h41; b_last = 1;
    cyc("b1_req", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("b1_b", 1, 1, 1, 8'h41, 1, 0, 1);
    nxt(); b_valid = 0; b_last = 0;
    cyc("b1_idle", 0, 1, 0, 8'h00, 0, 0, 0);

    // Priority A, both with 2-beat packets: A then B with no bubble
    nxt(); a_valid = 1; a_data = 8'h51; b_valid = 1; b_data = 8'h61;
    cyc("ab_req", 0, 1, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("ab_a1", 1, 0, 1, 8'h51, 0, 1, 0);
    nxt(); a_data = 8'h52; a_last = 1;
    cyc("ab_a2", 1, 0, 1, 8'h52, 1, 1, 0);
    nxt(); a_valid = 0; a_last = 0;
    cyc("ab_b1", 1, 1, 1, 8'h61, 0, 0, 1);
    nxt(); b_data = 8'h62; b_last = 1;
    cyc("ab_b2", 1, 1, 1, 8'h62, 1, 0, 1);
    nxt(); b_valid = 0; b_last = 0;
    cyc("ab_idle", 0, 1, 0, 8'h00, 0, 0, 0);

    // Burst truncation: A 6-beat packet vs B 1-beat packet, MAX_BURST=4
    nxt(); a_valid = 1; a_data = 8'h71; b_valid = 1; b_data = 8'h81; b_last = 1;
    cyc("bt_req", 0, 1, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("bt_a1", 1, 0, 1, 8'h71, 0, 1, 0);
    nxt(); a_data = 8'h72; cyc("bt_a2", 1, 0, 1, 8'h72, 0, 1, 0);
    nxt(); a_data = 8'h73; cyc("bt_a3", 1, 0, 1, 8'h73, 0, 1, 0);
    nxt(); a_data = 8'h74; cyc("bt_a4", 1, 0, 1, 8'h74, 1, 1, 0);
    nxt(); a_data = 8'h75; cyc("bt_b1", 1, 1, 1, 8'h81, 1, 0, 1);
    nxt(); b_valid = 0; b_last = 0;
    cyc("bt_a5", 1, 0, 1, 8'h75, 0, 1, 0);
    nxt(); a_data = 8'h76; a_last = 1;
    cyc("bt_a6", 1, 0, 1, 8'h76, 1, 1, 0);
    nxt(); a_valid = 0; a_last = 0;
    cyc("bt_idle", 0, 0, 0, 8'h00, 0, 0, 0);

    // Backpressure: 5 stalled cycles on beat 2 of a 3-beat packet
    nxt(); a_valid = 1; a_data = 8'h91;
    cyc("bp_req", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("bp_b1", 1, 0, 1, 8'h91, 0, 1, 0);
    nxt(); a_data = 8'h92; y_ready = 0;
    cyc("bp_s0", 1, 0, 1, 8'h92, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); cyc($sformatf("bp_s%0d", i + 1), 1, 0, 1, 8'h92, 0, 0, 0);
    end
    nxt(); y_ready = 1;
    cyc("bp_b2", 1, 0, 1, 8'h92, 0, 1, 0);
    nxt(); a_data = 8'h93; a_last = 1;
    cyc("bp_b3", 1, 0, 1, 8'h93, 1, 1, 0);
    nxt(); a_valid = 0; a_last = 0;
    cyc("bp_idle", 0, 0, 0, 8'h00, 0, 0, 0);

    // Reset on beat 2 of a 4-beat B packet
    nxt(); b_valid = 1; b_data = 8'hA1;
    cyc("rm_req", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("rm_b1", 1, 1, 1, 8'hA1, 0, 0, 1);
    nxt(); b_data = 8'hA2;
    cyc("rm_b2", 1, 1, 1, 8'hA2, 0, 0, 1);
    #1; rst_n = 0;
    cyc("rm_async", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); rst_n = 1; a_valid = 1; a_data = 8'hC1; a_last = 1; b_data = 8'hD1; b_last = 1;
    cyc("rm_rel", 0, 0, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("rm_a", 1, 0, 1, 8'hC1, 1, 1, 0);
    // en drops during B's grant: beat still completes, then no new grant
    nxt(); a_valid = 0; a_last = 0; en = 0;
    cyc("en_b", 1, 1, 1, 8'hD1, 1, 0, 1);
    nxt(); a_valid = 1; a_data = 8'hE1; a_last = 1;
    cyc("en_off0", 0, 1, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("en_off1", 0, 1, 0, 8'h00, 0, 0, 0);
    nxt(); en = 1;
    cyc("en_on", 0, 1, 0, 8'h00, 0, 0, 0);
    nxt(); cyc("en_a", 1, 0, 1, 8'hE1, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
